// File: rtl/reu_ram_bridge.sv
// reu_ram_bridge
// ---------------------------------------------------------------------------
// Bridges the REU's byte-wide expansion-RAM port onto a 16-bit pipelined
// (Avalon-MM style) memory bus. Each REU request becomes one bus command.
// The bridge then opens a ram_cycle window of SLOT_LEN clocks. ram_din is
// held constant for the whole window, because the REU samples it during
// that time.
//
// Optional feature: define REU_BRIDGE_CACHE_EN to add a one-word read cache.
// A read that hits the cache skips the bus entirely. Writes always go to the
// bus. A write whose word matches the cache tag also updates the matching
// cache lane.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ram_cs/ram_we         REU request strobe and direction (1 = write)
//   ram_addr              REU byte address (AW+1 bits)
//   ram_dout / ram_din    byte from REU / byte returned to REU
//   ram_cycle             slot strobe to REU
//   avm_address           word address (ram_addr[AW:1])
//   avm_read/avm_write    bus commands, held while avm_waitrequest is high
//   avm_writedata         write byte replicated on both lanes
//   avm_byteenable        2'b01 = even byte [7:0], 2'b10 = odd byte [15:8]
//   avm_waitrequest       command stall
//   avm_readdata/valid    read data return
// ---------------------------------------------------------------------------
module reu_ram_bridge #(
    parameter int SLOT_LEN = 4,
    parameter int AW       = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ram_cs,
    input  logic          ram_we,
    input  logic [AW:0]   ram_addr,
    input  logic [7:0]    ram_dout,
    output logic [7:0]    ram_din,
    output logic          ram_cycle,
    output logic [AW-1:0] avm_address,
    output logic          avm_read,
    output logic          avm_write,
    output logic [15:0]   avm_writedata,
    output logic [1:0]    avm_byteenable,
    input  logic          avm_waitrequest,
    input  logic [15:0]   avm_readdata,
    input  logic          avm_readdatavalid
);

    localparam int CW = $clog2(SLOT_LEN + 1);

    typedef enum logic [2:0] {IDLE, CMD, RDWAIT, SLOT, GAP} state_t;

    state_t        state;
    logic [CW-1:0] slot_cnt;
    logic          lat_we;
    logic          lat_lane;
    logic [7:0]    lat_dout;

    function automatic logic [7:0] pick_lane(input logic [15:0] word, input logic lane);
        return lane ? word[15:8] : word[7:0];
    endfunction

`ifdef REU_BRIDGE_CACHE_EN
    logic          cache_valid;
    logic [AW-1:0] cache_tag;
    logic [15:0]   cache_data;
    logic          cache_hit;
    logic          rd_capture;
    logic          wr_accept;

    assign cache_hit  = cache_valid && !ram_we && (cache_tag == ram_addr[AW:1]);
    // Read data can arrive on the acceptance clock itself as well as in RDWAIT.
    assign rd_capture = avm_readdatavalid &&
                        ((state == RDWAIT) ||
                         (state == CMD && !avm_waitrequest && !lat_we));
    assign wr_accept  = (state == CMD) && !avm_waitrequest && lat_we;

    // The tag is taken from avm_address, which holds the latched word
    // address for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (rd_capture) begin
            cache_valid <= 1'b1;
            cache_tag   <= avm_address;
            cache_data  <= avm_readdata;
        end else if (wr_accept && cache_valid && (cache_tag == avm_address)) begin
            if (lat_lane)
                cache_data[15:8] <= lat_dout;
            else
                cache_data[7:0]  <= lat_dout;
        end
    end
`endif

    // Main transaction FSM. All outputs are registered here.
    // The request is latched once in IDLE, so the REU may change its
    // request lines afterwards without affecting the transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ram_cycle      <= 1'b0;
            ram_din        <= 8'hFF;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            slot_cnt       <= '0;
            lat_we         <= 1'b0;
            lat_lane       <= 1'b0;
            lat_dout       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_cycle <= 1'b0;
                    if (ram_cs) begin
                        lat_we         <= ram_we;
                        lat_lane       <= ram_addr[0];
                        lat_dout       <= ram_dout;
                        avm_address    <= ram_addr[AW:1];
                        avm_byteenable <= ram_addr[0] ? 2'b10 : 2'b01;
                        avm_writedata  <= {ram_dout, ram_dout};
                        avm_read       <= !ram_we;
                        avm_write      <= ram_we;
                        state          <= CMD;
`ifdef REU_BRIDGE_CACHE_EN
                        // A cache hit overrides the bus command issued above.
                        if (cache_hit) begin
                            avm_read  <= 1'b0;
                            avm_write <= 1'b0;
                            ram_din   <= pick_lane(cache_data, ram_addr[0]);
                            state     <= SLOT;
                        end
`endif
                    end
                end
                CMD: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (lat_we) begin
                            // The REU stores ram_din after writes as well,
                            // so the write byte is echoed back.
                            ram_din <= lat_dout;
                            state   <= SLOT;
                        end else if (avm_readdatavalid) begin
                            ram_din <= pick_lane(avm_readdata, lat_lane);
                            state   <= SLOT;
                        end else begin
                            state   <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (avm_readdatavalid) begin
                        ram_din <= pick_lane(avm_readdata, lat_lane);
                        state   <= SLOT;
                    end
                end
                SLOT: begin
                    // Entering SLOT with ram_cycle low guarantees one clock
                    // between the ram_din update and the first high clock.
                    if (!ram_cycle) begin
                        ram_cycle <= 1'b1;
                        slot_cnt  <= CW'(SLOT_LEN - 1);
                    end else if (slot_cnt == '0) begin
                        ram_cycle <= 1'b0;
                        state     <= GAP;
                    end else begin
                        slot_cnt  <= slot_cnt - CW'(1);
                    end
                end
                GAP: begin
                    // The REU must see ram_cs drop before a new request starts.
                    ram_cycle <= 1'b0;
                    if (!ram_cs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/reu_ram_bridge.md
Name: reu_ram_bridge

Overview:
- Sits directly downstream of the REU's expansion-RAM port.
- Converts the REU's byte-wide request (ram_cs/ram_we/ram_addr/ram_dout) into 16-bit pipelined memory-bus transactions toward the SDRAM/HyperRAM controller.
- Generates the ram_cycle strobe window in which the REU samples ram_din.
- Guarantees read data, or the echoed write byte, is stable for the whole window.

Parameters:
- SLOT_LEN, 4, ram_cycle high length in clocks; must match the REU's 4-clock sampling count.
- AW, 24, word-address width on the memory bus (byte address width is AW+1).

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high.
- ram_cs in 1: REU request, held until the slot completes.
- ram_we in 1: 1 = write, 0 = read; valid while ram_cs.
- ram_addr in AW+1: byte address; valid while ram_cs.
- ram_dout in 8: write byte from REU.
- ram_din out 8: byte to REU.
- ram_cycle out 1: slot strobe to REU.
- avm_address out AW: word address.
- avm_read out 1: read command.
- avm_write out 1: write command.
- avm_writedata out 16: write data.
- avm_byteenable out 2: byte lanes.
- avm_waitrequest in 1: command stall.
- avm_readdata in 16: read data.
- avm_readdatavalid in 1: read data strobe.

Behaviour:
- Reset values: ram_cycle 0, ram_din 8'hFF, avm_read 0, avm_write 0, avm_address 0, avm_writedata 0, avm_byteenable 0, state IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The memory controller shares this reset, so no readdatavalid arrives after reset.
- Lane mapping: even byte = [7:0], odd byte = [15:8].
  - avm_address = ram_addr[AW:1].
  - avm_byteenable = ram_addr[0] ? 2'b10 : 2'b01.
  - avm_writedata = {ram_dout, ram_dout}.
- The request (addr, we, dout) is latched on acceptance. Later changes on the request inputs are ignored until the next acceptance.
- IDLE:
  - ram_cycle = 0.
  - On ram_cs = 1: latch the request, drive avm_read or avm_write = 1 on the next clock, go to CMD.
- CMD:
  - Hold the command until a clock with avm_waitrequest = 0; that clock is acceptance.
  - Drop avm_read/avm_write the clock after acceptance.
  - Write → SLOT, with ram_din = latched ram_dout (echo). The REU stores ram_din after writes too, so the echo is mandatory.
  - Read → RDWAIT.
- RDWAIT:
  - On avm_readdatavalid, register the selected byte into ram_din and go to SLOT.
  - readdatavalid on the acceptance clock itself is legal.
  - No timeout.
- SLOT:
  - ram_cycle = 1 for exactly SLOT_LEN consecutive clocks, with ram_din constant throughout.
  - Then ram_cycle = 0 and go to GAP.
  - The first ram_cycle high comes no earlier than 1 clock after ram_din is updated.
- GAP:
  - ram_cycle = 0.
  - Wait for a clock with ram_cs = 0, then go to IDLE.
  - Guarantees at least one low ram_cycle clock between slots, so the REU's EVAL sees ~ram_cycle.
- ram_cs dropping before the slot ends: the current transaction still completes on the bus, the slot still runs SLOT_LEN, then return to IDLE.
- ram_din holds its last value outside slots.
- Latency with zero waitrequest and readdatavalid at acceptance+1:
  - Write: ram_cs to first ram_cycle = 3 clocks.
  - Read: ram_cs to first ram_cycle = 4 clocks.
- Only one transaction is outstanding at any time.

Optional Feature:
- REU_BRIDGE_CACHE_EN: one-word read cache (tag = word address, data = 16 bits, valid bit cleared by reset).
- Read with valid and tag match: skip CMD/RDWAIT and go directly to SLOT using the cached byte. No bus traffic.
- Read miss: fill the cache on readdatavalid.
- Write: always goes to the bus. On a tag hit, also update the addressed cache byte lane.
- Without the macro: every request goes to the bus, and no cache storage is synthesised.

Test Plan:
- Read: ram_addr 0x1000001, memory word 0x800000 = 16'hA55A, waitrequest 0, readdatavalid next clock → avm_address 0x800000, byteenable 2'b10, ram_cycle high exactly 4 clocks, ram_din = 8'hA5 stable throughout.
- Write: ram_addr 0x1000000, ram_dout 8'h3C, waitrequest high 5 clocks → avm_write held 6 clocks, writedata 16'h3C3C, byteenable 2'b01, ram_din = 8'h3C during the slot.
- Back-to-back: REU swap sequence of a read, then a write to 0x1000002 → ram_cycle low ≥1 clock between slots, no overlapping bus commands, memory word 0x800001 low byte updated.
- Reset asserted in RDWAIT → next clock ram_cycle 0, avm_read 0, ram_din 8'hFF; a fresh read afterwards completes normally.
- ram_cs dropped during CMD → command still completes, one 4-clock slot, then IDLE.
- With REU_BRIDGE_CACHE_EN: read 0x1000004, then read 0x1000005 → second read issues no avm_read and returns the high byte; a write to 0x1000005 followed by a read of it returns the new byte.
